// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared encodings and helpers for the byte-serial memory access unit
package mau_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

  function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

  // Big-endian serialisation: byte idx of an nbytes-wide right-aligned store value.
  function automatic logic [7:0] store_byte(input logic [31:0] wdata,
                                            input logic [2:0]  nbytes,
                                            input logic [2:0]  idx);
    logic [2:0] sh;
    sh = nbytes - idx - 3'd1;
    return 8'(wdata >> {sh, 3'b000});
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of the assembled load accumulator
module load_extend
  import mau_pkg::*;
(
  input  logic [31:0] i_acc,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_acc;
    case (i_size)
      SIZE_BYTE: o_data = {{24{i_signed & i_acc[7]}}, i_acc[7:0]};
      SIZE_HALF: o_data = {{16{i_signed & i_acc[15]}}, i_acc[15:0]};
      default:   o_data = i_acc;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - serialises one lw/lh/lb/sw/sh/sb request into byte transfers
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata
);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_count, w_count_nxt;
  logic        r_write, r_signed, r_rd_pend;
  logic [1:0]  r_size;
  logic [31:0] r_base, r_wdata, r_acc;

  logic        r_req_ready, r_resp_valid, r_resp_err, r_mem_we, r_mem_re;
  logic [31:0] r_resp_rdata, r_mem_addr;
  logic [7:0]  r_mem_wdata;

  logic        w_latch, w_err_in, w_ready_nxt, w_rv_nxt, w_err_nxt, w_we_nxt, w_re_nxt;
  logic [2:0]  w_nbytes_in, w_nbytes;
  logic [1:0]  w_cnt_inc;
  logic [32:0] w_end_in;
  logic [31:0] w_acc_nxt, w_ext, w_rdata_nxt, w_addr_nxt;
  logic [7:0]  w_wdata_nxt;

  assign w_nbytes_in = size_to_nbytes(req_size);
  assign w_nbytes    = size_to_nbytes(r_size);
  assign w_cnt_inc   = r_count + 2'd1;
  // 33-bit sum so a request near 0xFFFFFFFF cannot wrap back into range.
  assign w_end_in    = {1'b0, req_addr} + 33'(w_nbytes_in) - 33'd1;
  assign w_err_in    = (req_size == SIZE_ILL)
                     | ((req_size == SIZE_HALF) & req_addr[0])
                     | ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00))
                     | (w_end_in >= 33'(MEM_BYTES));
  assign w_acc_nxt   = r_rd_pend ? {r_acc[23:0], mem_rdata} : r_acc;

  load_extend u_load_extend (
    .i_acc    (w_acc_nxt),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_latch     = 1'b0;
    w_we_nxt    = 1'b0;
    w_re_nxt    = 1'b0;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_rv_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = 32'd0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_latch = 1'b1;
          if (w_err_in) begin
            w_state_nxt = RESP;
            w_rv_nxt    = 1'b1;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = XFER;
            w_count_nxt = 2'd0;
            w_addr_nxt  = req_addr;
            w_we_nxt    = req_write;
            w_re_nxt    = ~req_write;
            w_wdata_nxt = store_byte(req_wdata, w_nbytes_in, 3'd0);
          end
        end
      end
      XFER: begin
        if ({1'b0, r_count} == w_nbytes - 3'd1) begin
          w_state_nxt = DRAIN;
        end else begin
          w_count_nxt = w_cnt_inc;
          w_addr_nxt  = r_base + {30'd0, w_cnt_inc};
          w_we_nxt    = r_write;
          w_re_nxt    = ~r_write;
          w_wdata_nxt = store_byte(r_wdata, w_nbytes, {1'b0, w_cnt_inc});
        end
      end
      DRAIN: begin
        w_state_nxt = RESP;
        w_rv_nxt    = 1'b1;
        w_rdata_nxt = r_write ? 32'd0 : w_ext;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_count      <= 2'd0;
      r_write      <= 1'b0;
      r_size       <= SIZE_BYTE;
      r_signed     <= 1'b0;
      r_base       <= 32'd0;
      r_wdata      <= 32'd0;
      r_acc        <= 32'd0;
      r_rd_pend    <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 8'd0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_rd_pend    <= r_mem_re;
      r_acc        <= w_latch ? 32'd0 : w_acc_nxt;
      r_req_ready  <= w_ready_nxt;
      r_resp_valid <= w_rv_nxt;
      r_resp_rdata <= w_rdata_nxt;
      r_resp_err   <= w_err_nxt;
      r_mem_addr   <= w_addr_nxt;
      r_mem_wdata  <= w_wdata_nxt;
      r_mem_we     <= w_we_nxt;
      r_mem_re     <= w_re_nxt;
      if (w_latch) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_base   <= req_addr;
        r_wdata  <= req_wdata;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_we     = r_mem_we;
  assign mem_re     = r_mem_re;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a 32-byte memory
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  logic [7:0] mem     [32];
  logic [7:0] ref_mem [32];
  logic [7:0] rdq = 8'd0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory ignores its port while the system is held in reset.
  always @(posedge clk) begin
    if (!rst) begin
      if (mem_we === 1'b1 && mem_addr < 32) mem[mem_addr[4:0]] <= mem_wdata;
      if (mem_re === 1'b1 && mem_addr < 32) rdq <= mem[mem_addr[4:0]];
    end
  end
  assign mem_rdata = rdq;

  typedef struct {logic err; logic [31:0] rdata; int cyc;} resp_t;
  typedef struct {logic [31:0] addr; logic we; logic [7:0] wdata; int cyc;} xfer_t;
  resp_t rq[$];
  xfer_t xq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_line(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s actual=%0h required=nothing", name, act);
  endtask

  always @(negedge clk) begin : xfer_mon
    xfer_t e;
    if (mem_we === 1'b1 || mem_re === 1'b1) begin
      chk("strobe_exclusive", 32'(mem_we & mem_re), 32'd0);
      if (xq.size() == 0) fail_line("unexpected_strobe", mem_addr);
      else begin
        e = xq.pop_front();
        chk("xfer_addr", mem_addr, e.addr);
        chk("xfer_we", 32'(mem_we), 32'(e.we));
        if (e.we) chk("xfer_wdata", 32'(mem_wdata), 32'(e.wdata));
        chk("xfer_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : resp_mon
    resp_t e;
    if (resp_valid === 1'b1) begin
      if (rq.size() == 0) fail_line("unexpected_resp", resp_rdata);
      else begin
        e = rq.pop_front();
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Reference: expected transfers and response from the request rules alone.
  task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input int t,
                       input bit abort);
    int n;
    longint last;
    logic [31:0] val;
    logic [7:0] b;
    bit err;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    last = {32'd0, a};
    last = last + n - 1;
    err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (last >= 32);
    if (err) begin
      rq.push_back('{1'b1, 32'd0, t + 1});
      return;
    end
    val = 32'd0;
    for (int i = 0; i < n; i++) begin
      if (abort && i >= 2) break;
      if (w) begin
        b = 8'(wd >> (8 * (n - 1 - i)));
        xq.push_back('{a + i, 1'b1, b, t + 1 + i});
        if (!abort || i == 0) ref_mem[a[4:0] + i] = b;
      end else begin
        xq.push_back('{a + i, 1'b0, 8'd0, t + 1 + i});
        val = (val << 8) | {24'd0, ref_mem[a[4:0] + i]};
      end
    end
    if (abort) return;
    if (!w && n == 1) val = sg ? {{24{val[7]}}, val[7:0]} : {24'd0, val[7:0]};
    if (!w && n == 2) val = sg ? {{16{val[15]}}, val[15:0]} : {16'd0, val[15:0]};
    rq.push_back('{1'b0, w ? 32'd0 : val, t + n + 2});
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit abort,
                       output int t);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    t = -1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready === 1'b1) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) fail_line("accept_timeout", a);
    else model(w, sz, sg, a, wd, t, abort);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int i = 0; i < 100 && (rq.size() != 0 || xq.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  int t1, t2, t;

  initial begin : wdog
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_strobes", 32'({mem_we, mem_re}), 32'd0);
    rst = 1'b0;

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, t); drain();
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, t); drain();
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0, t); drain();
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0, t); drain();

    issue(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 1'b0, t); drain();
    issue(1'b1, 2'd1, 1'b0, 32'h03, 32'h1234, 1'b0, t); drain();
    issue(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 1'b0, t); drain();
    issue(1'b0, 2'd2, 1'b0, 32'h1E, 32'h0, 1'b0, t); drain();
    issue(1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b0, t); drain();

    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, t1);
    issue(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 1'b0, t2);
    chk("backtoback_gap", 32'(t2 - t1), 32'd7);
    drain();

    issue(1'b1, 2'd2, 1'b0, 32'h00, 32'hCAFEF00D, 1'b1, t);
    req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_cycle", 32'(cyc), 32'(t + 3));
    chk("abort_strobes", 32'({mem_we, mem_re}), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_no_resp", 32'(resp_valid), 32'd0);
    drain();
    for (int i = 0; i < 4; i++) chk("abort_mem", 32'(mem[i]), 32'(ref_mem[i]));

    issue(1'b1, 2'd0, 1'b0, 32'h1F, 32'h12345680, 1'b0, t); drain();
    issue(1'b0, 2'd0, 1'b1, 32'h1F, 32'h0, 1'b0, t); drain();

    for (int k = 0; k < 60; k++) begin
      logic [1:0] sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 33));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, t);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    chk("resp_queue_empty", 32'(rq.size()), 32'd0);
    chk("xfer_queue_empty", 32'(xq.size()), 32'd0);
    for (int i = 0; i < 32; i++) chk("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
